smpl_queue_seq: RTL
===================

Name: smpl_queue_seq

Overview:
- Per-band circular sample queue that sits upstream of each FIR band filter.
- Stores incoming stereo samples on every `wrt_smpl` strobe.
- After each new sample, once at least TAPS samples have been stored, it replays the most recent TAPS samples, oldest first, on `lft_out`/`rght_out`.
- It frames each replay burst with `sequencing`, timed so the FIR's registered coefficient ROM lines up with the sample stream.

Parameters:
- DEPTH, 1024, storage entries; must be a power of two and greater than TAPS.
- TAPS, 1021, samples replayed per burst; equals the FIR coefficient count.
- ADDR_W, 10, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wrt_smpl  input  1  one-cycle strobe: new sample present on lft_smpl/rght_smpl
- lft_smpl  input  16  signed left sample in
- rght_smpl  input  16  signed right sample in
- sequencing  output  1  high for exactly TAPS+1 consecutive cycles per burst
- lft_out  output  16  signed left sample to FIR
- rght_out  output  16  signed right sample to FIR

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All state is cleared on rst_n low.
- Reset values: sequencing=0, lft_out=0, rght_out=0, wr_ptr=0, rd_ptr=0, fill count=0, state=IDLE. Memory contents are not reset.
- Storage: one DEPTH x 32 register-array RAM {lft,rght}, with a synchronous write and a registered read (1-cycle latency). lft_out/rght_out are the registered read data.
- Write (cycle W, wrt_smpl=1 in IDLE):
  - mem[wr_ptr] <= {lft_smpl,rght_smpl}.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - Fill count increments, saturating at TAPS.
- Launch: if the fill count after the write is >= TAPS:
  - state -> SEQ at W+1.
  - rd_ptr is loaded with (wr_ptr_after_write - TAPS) mod DEPTH, which addresses the oldest of the newest TAPS samples.
- States:
  - IDLE: sequencing=0; waits for wrt_smpl.
  - SEQ: sequencing=1; issue read at rd_ptr, rd_ptr++ (wrapping), increment burst counter. After TAPS reads have been issued, one further cycle with sequencing=1 lets the last read data arrive; then -> IDLE.
- Timing contract:
  - sequencing rises at W+1 and stays high through W+1+TAPS (TAPS+1 cycles), falling at W+TAPS+2.
  - Sample k of the burst (k=0 oldest .. TAPS-1 newest, the newest being the sample written at W) appears on lft_out/rght_out in cycle W+2+k.
- Between bursts, lft_out/rght_out hold their last value.
- Fill phase: the first TAPS-1 writes after reset store data only. The TAPS-th write triggers the first burst.
- Pointer wrap: rd_ptr and wr_ptr wrap modulo DEPTH with no discontinuity in sample order.
- wrt_smpl while in SEQ: the sample is dropped (no write, no pointer or count change).
- wrt_smpl in the same cycle as the SEQ -> IDLE transition: treated as a SEQ-cycle strobe and dropped.
- Reset mid-burst: sequencing drops immediately, pointers and count clear, and a fresh fill phase is required.

Optional Feature:
- Macro: SMPL_QUEUE_OVERRUN_EN.
- Defined:
  - Adds output port overrun (1 bit, reset 0). It is a sticky flag set when wrt_smpl arrives while in SEQ, cleared only by rst_n.
  - Adds output port drop_cnt (8 bits, reset 0), which increments on each dropped sample and saturates at 255.
- Undefined: neither port exists; dropped samples are silent.

Test Plan:
- DEPTH=8, TAPS=5: write samples 1..4 (lft=n, rght=-n), 20 cycles apart -> sequencing stays 0 throughout.
- Continue the previous test: write sample 5 at cycle W -> sequencing high at W+1..W+6 (6 cycles), lft_out = 1,2,3,4,5 at W+2..W+6, rght_out = -1..-5, then sequencing low at W+7.
- Wrap: keep writing samples 6..12 with gaps of 10 cycles -> the burst after sample 12 outputs 8,9,10,11,12 oldest first, with no glitch across the pointer wrap at entry 7 -> 0.
- Drop: assert wrt_smpl with value 99 at W+3 during a burst -> 99 never appears in any later burst. With SMPL_QUEUE_OVERRUN_EN defined, overrun=1 and drop_cnt=1 from W+4.
- Reset mid-burst: pull rst_n low at W+3 -> sequencing=0, lft_out=0 and rght_out=0 asynchronously. After release, 4 further writes produce no sequencing; the 5th write starts a burst.
- Back-to-back: write exactly at W+7, the first IDLE cycle after a burst -> new burst starts at W+8 with the window shifted by one sample.

Source files
------------

// File: rtl/smpl_queue_seq.sv
// Circular stereo sample queue that replays the newest TAPS samples, oldest first, to a FIR band filter.
// Optional macro SMPL_QUEUE_OVERRUN_EN adds the overrun flag and drop_cnt counter outputs.
module smpl_queue_seq #(
  parameter int DEPTH  = 1024,
  parameter int TAPS   = 1021,
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out
`ifdef SMPL_QUEUE_OVERRUN_EN
  ,
  output logic               overrun,
  output logic [7:0]         drop_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rd_data_q;

  state_t            state_q;
  logic              seq_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] fill_q;
  logic [ADDR_W-1:0] burst_q;

  logic              wr_en;
  logic              rd_en;
  logic              launch;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic [ADDR_W-1:0] fill_d;
  logic [ADDR_W-1:0] rd_start_d;

  // Strobes arriving while a burst is running are discarded, not queued.
  assign wr_en      = (state_q == IDLE) && wrt_smpl;
  assign rd_en      = (state_q == SEQ) && (burst_q != TAPS_A);
  assign wr_ptr_d   = wr_ptr_q + ONE_A;
  assign fill_d     = (fill_q == TAPS_A) ? fill_q : fill_q + ONE_A;
  assign launch     = wr_en && (fill_d == TAPS_A);
  assign rd_start_d = wr_ptr_d - TAPS_A;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {lft_smpl, rght_smpl};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 32'd0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // The extra SEQ cycle after the last read keeps sequencing high while its data lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      seq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      burst_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            if (launch) begin
              state_q  <= SEQ;
              seq_q    <= 1'b1;
              rd_ptr_q <= rd_start_d;
              burst_q  <= '0;
            end
          end
        end
        SEQ: begin
          if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + ONE_A;
            burst_q  <= burst_q + ONE_A;
          end else begin
            state_q <= IDLE;
            seq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          seq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sequencing = seq_q;
  assign lft_out    = rd_data_q[31:16];
  assign rght_out   = rd_data_q[15:0];

`ifdef SMPL_QUEUE_OVERRUN_EN
  logic       overrun_q;
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if ((state_q == SEQ) && wrt_smpl) begin
      overrun_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
